// File: rtl/shared_register_arbiter.sv
// Shared register with round-robin write arbitration.
// Several requesters compete to write one stored word. One writer is granted
// per cycle, starting the search at a rotating priority pointer so every
// persistent requester is served within REQUESTER_COUNT cycles.
module shared_register_arbiter #(
    parameter int WORD_WIDTH      = 0,
    parameter int REQUESTER_COUNT = 0,
    parameter     RESET_VALUE     = 0,
    // Widths are clamped so an instance left at the default values still elaborates
    localparam int WW = (WORD_WIDTH < 1) ? 1 : WORD_WIDTH,
    localparam int RC = (REQUESTER_COUNT < 2) ? 2 : REQUESTER_COUNT,
    localparam int PW = $clog2(RC)
) (
    input  logic             clock,
    input  logic             areset,
    input  logic             clear,
    input  logic [RC-1:0]    requests_valid,
    output logic [RC-1:0]    requests_ready,
    input  logic [RC*WW-1:0] requests_data,
    output logic [WW-1:0]    data_out,
    output logic             data_out_updated,
    output logic [PW-1:0]    last_writer
);

    localparam logic [WW-1:0] RESET_WORD = WW'(RESET_VALUE);
    localparam logic [PW:0]   RC_WIDE    = (PW+1)'(RC);
    localparam logic [PW-1:0] LAST_IDX   = PW'(RC - 1);

    // Registered state
    logic [WW-1:0] data_p1;
    logic [PW-1:0] pointer_p1;
    logic [PW-1:0] writer_p1;
    logic          vld_p1;

    // Arbitration results for the current cycle
    logic          found_p0;
    logic [PW:0]   cand_p0;
    logic [PW-1:0] grant_idx_p0;
    logic [PW-1:0] next_ptr_p0;
    logic          xfer_p0;
    logic [WW-1:0] grant_word_p0;

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        found_p0     = 1'b0;
        cand_p0      = '0;
        grant_idx_p0 = '0;
        for (int off = 0; off < RC; off++) begin
            cand_p0 = {1'b0, pointer_p1} + (PW+1)'(off);
            if (cand_p0 >= RC_WIDE) begin
                cand_p0 = cand_p0 - RC_WIDE;
            end
            if (!found_p0 && requests_valid[cand_p0[PW-1:0]]) begin
                found_p0     = 1'b1;
                grant_idx_p0 = cand_p0[PW-1:0];
            end
        end
    end

    // Grant qualification: clear and reset both suppress any acceptance
    always_comb begin
        xfer_p0        = found_p0 && !clear && !areset;
        requests_ready = xfer_p0 ? (RC'(1) << grant_idx_p0) : '0;
        next_ptr_p0    = (grant_idx_p0 == LAST_IDX) ? '0 : grant_idx_p0 + PW'(1);
        grant_word_p0  = requests_data[grant_idx_p0*WW +: WW];
    end

    // ---- stage boundary: p0 -> p1 ----
    // Store the granted word; clear takes priority over any write
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            data_p1    <= RESET_WORD;
            pointer_p1 <= '0;
            writer_p1  <= '0;
            vld_p1     <= 1'b0;
        end else if (clear) begin
            data_p1    <= RESET_WORD;
            pointer_p1 <= '0;
            writer_p1  <= '0;
            vld_p1     <= 1'b1;
        end else if (xfer_p0) begin
            data_p1    <= grant_word_p0;
            pointer_p1 <= next_ptr_p0;
            writer_p1  <= grant_idx_p0;
            vld_p1     <= 1'b1;
        end else begin
            vld_p1     <= 1'b0;
        end
    end

    assign data_out         = data_p1;
    assign data_out_updated = vld_p1;
    assign last_writer      = writer_p1;

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Directed and randomized bench for shared_register_arbiter (4 requesters, 8-bit words).
module tb_shared_register_arbiter;

    logic        clock;
    logic        clk_en;
    logic        areset;
    logic        clear;
    logic [3:0]  requests_valid;
    logic [3:0]  requests_ready;
    logic [31:0] requests_data;
    logic [7:0]  data_out;
    logic        data_out_updated;
    logic [1:0]  last_writer;

    logic [7:0]  dw [4];

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] w;
        logic       u;
    } exp_t;

    exp_t        sb [$];
    logic [7:0]  cur_d;
    logic [1:0]  cur_w;
    logic [1:0]  mdl_ptr;
    logic [3:0]  obs_rdy;
    int          checks;
    int          passed;

    assign requests_data = {dw[3], dw[2], dw[1], dw[0]};

    shared_register_arbiter #(
        .WORD_WIDTH      (8),
        .REQUESTER_COUNT (4),
        .RESET_VALUE     (8'h5A)
    ) dut (
        .clock            (clock),
        .areset           (areset),
        .clear            (clear),
        .requests_valid   (requests_valid),
        .requests_ready   (requests_ready),
        .requests_data    (requests_data),
        .data_out         (data_out),
        .data_out_updated (data_out_updated),
        .last_writer      (last_writer)
    );

    // Clock held still until the bench enables it
    always #5 if (clk_en) clock = ~clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    endtask

    // Reference round-robin pick: rotate the request vector by the pointer
    function automatic logic [3:0] rr(input logic [3:0] v, input logic [1:0] p);
        logic [7:0] dbl;
        logic [3:0] one;
        one = 4'b0001;
        dbl = {v, v} >> p;
        for (int k = 0; k < 4; k++) begin
            if (dbl[k]) return one << ((int'(p) + k) % 4);
        end
        return 4'b0000;
    endfunction

    // Push the expected post-edge state for the stimulus of this cycle
    task automatic expect_edge(input logic clr, input logic [3:0] rdy);
        exp_t e;
        if (clr) begin
            cur_d   = 8'h5A;
            cur_w   = 2'd0;
            mdl_ptr = 2'd0;
            e = '{d: cur_d, w: cur_w, u: 1'b1};
        end else if (rdy != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (rdy[k]) begin
                    cur_d   = dw[k];
                    cur_w   = 2'(k);
                    mdl_ptr = 2'(k + 1);
                end
            end
            e = '{d: cur_d, w: cur_w, u: 1'b1};
        end else begin
            e = '{d: cur_d, w: cur_w, u: 1'b0};
        end
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"},    {24'd0, data_out},        {24'd0, e.d});
            check({tag, "_writer"},  {30'd0, last_writer},     {30'd0, e.w});
            check({tag, "_updated"}, {31'd0, data_out_updated}, {31'd0, e.u});
        end
    endtask

    // One clock cycle: drive at negedge, check ready, then check state after posedge
    task automatic step(input string tag, input logic [3:0] v, input logic clr, input logic [3:0] exp_rdy);
        @(negedge clock);
        requests_valid = v;
        clear          = clr;
        #1;
        obs_rdy = requests_ready;
        check({tag, "_ready"}, {28'd0, requests_ready}, {28'd0, exp_rdy});
        expect_edge(clr, exp_rdy);
        @(posedge clock);
        #1;
        pop_check(tag);
    endtask

    initial begin
        int run3;
        int maxrun3;
        logic [3:0] v;
        logic [3:0] e;
        checks = 0;
        passed = 0;
        clock  = 1'b0;
        clk_en = 1'b0;
        areset = 1'b0;
        clear  = 1'b0;
        requests_valid = 4'hF;
        dw[0] = 8'h10; dw[1] = 8'h11; dw[2] = 8'h12; dw[3] = 8'h13;
        cur_d = 8'h5A; cur_w = 2'd0; mdl_ptr = 2'd0;

        // Reset pulse with the clock stopped
        #2 areset = 1'b1;
        #1 check("rst_ready", {28'd0, requests_ready}, 32'd0);
        #2 areset = 1'b0;
        #1;
        check("rst_data",    {24'd0, data_out}, 32'h5A);
        check("rst_writer",  {30'd0, last_writer}, 32'd0);
        check("rst_updated", {31'd0, data_out_updated}, 32'd0);
        requests_valid = 4'h0;
        clk_en = 1'b1;

        // Idle: nothing granted, state holds
        step("idle", 4'b0000, 1'b0, 4'b0000);

        // All requesters valid: strict rotation 0,1,2,3,0,...
        step("rr0", 4'b1111, 1'b0, 4'b0001);
        step("rr1", 4'b1111, 1'b0, 4'b0010);
        step("rr2", 4'b1111, 1'b0, 4'b0100);
        step("rr3", 4'b1111, 1'b0, 4'b1000);
        step("rr4", 4'b1111, 1'b0, 4'b0001);
        step("rr5", 4'b1111, 1'b0, 4'b0010);
        step("rr6", 4'b1111, 1'b0, 4'b0100);
        step("rr7", 4'b1111, 1'b0, 4'b1000);

        // Lone requester 2 after a grant to 3; pointer then sits at 3
        dw[2] = 8'hC3;
        step("lone2", 4'b0100, 1'b0, 4'b0100);
        step("ptr3", 4'b1001, 1'b0, 4'b1000);

        // Clear beats pending requests and rewinds the pointer
        step("pre_clr", 4'b0010, 1'b0, 4'b0010);
        step("clr", 4'b0011, 1'b1, 4'b0000);
        step("post_clr", 4'b0101, 1'b0, 4'b0001);

        // Reset while requester 1 holds ready: its word must be dropped
        step("pre_rst", 4'b0010, 1'b0, 4'b0010);
        dw[1] = 8'h77;
        @(negedge clock);
        requests_valid = 4'b0010;
        #1;
        check("mid_ready", {28'd0, requests_ready}, 32'b0010);
        areset = 1'b1;
        #1;
        check("ar_ready",   {28'd0, requests_ready}, 32'd0);
        check("ar_data",    {24'd0, data_out}, 32'h5A);
        check("ar_writer",  {30'd0, last_writer}, 32'd0);
        check("ar_updated", {31'd0, data_out_updated}, 32'd0);
        cur_d = 8'h5A; cur_w = 2'd0; mdl_ptr = 2'd0;
        @(posedge clock);
        #1;
        check("ar_edge_data", {24'd0, data_out}, 32'h5A);
        check("ar_edge_upd",  {31'd0, data_out_updated}, 32'd0);
        areset = 1'b0;
        step("post_rst", 4'b1010, 1'b0, 4'b0010);

        // Requester 3 always valid, others random: no starvation
        run3    = 0;
        maxrun3 = 0;
        for (int i = 0; i < 24; i++) begin
            v = {1'b1, 3'($urandom_range(0, 7))};
            e = rr(v, mdl_ptr);
            step("rand", v, 1'b0, e);
            if (obs_rdy[3]) begin
                run3 = 0;
            end else begin
                run3++;
                if (run3 > maxrun3) maxrun3 = run3;
            end
        end
        check("starve_gap", maxrun3 <= 3 ? 32'd1 : 32'd0, 32'd1);

        step("final_idle", 4'b0000, 1'b0, 4'b0000);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
